// File: rtl/sprite_draw_datapath.sv
// Sprite draw datapath: tracks the sprite position from the movement FSM
// state code and scans the sprite rectangle out as a stream of pixel
// writes (x, y, colour, plot) for CLEAR and DRAW passes.
//
// STATE code | meaning
// -----------+-----------------------------------------------------------
// 0100       | PREHOLD - idle, no movement, no pass
// 0000       | HOLD    - idle, no movement, no pass
// 0001       | CLEAR   - scan the sprite rectangle in BG_COLOUR
// 0011       | LEFT    - on entry, posX -= STEP (floor 0)
// 0010       | RIGHT   - on entry, posX += STEP (ceiling SCREEN_W-SPRITE_W)
// 0110       | DOWN    - on entry, posY += STEP (ceiling SCREEN_H-SPRITE_H)
// 0111       | UP      - on entry, posY -= STEP (floor 0)
// 0101       | DRAW    - scan the sprite rectangle in SPRITE_COLOUR
// others     | treated as idle, like HOLD
//
// The state code comes from an external movement FSM. An "entry cycle" is
// any cycle in which STATE differs from the copy registered on the
// previous edge; moves and pass starts only ever happen on entry cycles.
module sprite_draw_datapath #(
   parameter int         SPRITE_W      = 8,
   parameter int         SPRITE_H      = 8,
   parameter int         SCREEN_W      = 160,
   parameter int         SCREEN_H      = 120,
   parameter int         STEP          = 4,
   parameter int         START_X       = 76,
   parameter int         START_Y       = 56,
   parameter logic [2:0] SPRITE_COLOUR = 3'b110,
   parameter logic [2:0] BG_COLOUR     = 3'b000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] STATE,
   output logic       doneDrawing,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] colour,
   output logic       plot
);

   typedef enum logic [3:0] {
      ST_HOLD    = 4'b0000,
      ST_CLEAR   = 4'b0001,
      ST_RIGHT   = 4'b0010,
      ST_LEFT    = 4'b0011,
      ST_PREHOLD = 4'b0100,
      ST_DRAW    = 4'b0101,
      ST_DOWN    = 4'b0110,
      ST_UP      = 4'b0111
   } state_code_t;

   localparam logic [7:0] START_X_L = 8'(START_X);
   localparam logic [6:0] START_Y_L = 7'(START_Y);
   localparam logic [8:0] MAX_X     = 9'(SCREEN_W - SPRITE_W);
   localparam logic [7:0] MAX_Y     = 8'(SCREEN_H - SPRITE_H);
   localparam logic [8:0] STEP_X    = 9'(STEP);
   localparam logic [7:0] STEP_Y    = 8'(STEP);
   localparam logic [4:0] CX_LAST   = 5'(SPRITE_W - 1);
   localparam logic [4:0] CY_LAST   = 5'(SPRITE_H - 1);

   logic [3:0] last_state;
   logic [7:0] pos_x;
   logic [6:0] pos_y;
   logic [7:0] next_pos_x;
   logic [6:0] next_pos_y;
   logic [4:0] cx;
   logic [4:0] cy;
   logic       busy;
   logic       done;

   logic       entry;
   logic       pass_state;
   logic       last_px;
   logic [2:0] pix_colour;

   logic [8:0] sum_x;
   logic [8:0] diff_x;
   logic [7:0] sum_y;
   logic [7:0] diff_y;
   logic [7:0] left_x;
   logic [7:0] right_x;
   logic [6:0] up_y;
   logic [6:0] down_y;

   // Decode the incoming state code relative to the registered copy.
   always_comb begin
      entry      = (STATE != last_state);
      pass_state = (STATE == ST_CLEAR) || (STATE == ST_DRAW);
      last_px    = (cx == CX_LAST) && (cy == CY_LAST);
      pix_colour = (STATE == ST_DRAW) ? SPRITE_COLOUR : BG_COLOUR;
   end

   // Saturating step arithmetic; one extra bit catches borrow/overflow.
   always_comb begin
      sum_x   = {1'b0, pos_x} + STEP_X;
      diff_x  = {1'b0, pos_x} - STEP_X;
      sum_y   = {1'b0, pos_y} + STEP_Y;
      diff_y  = {1'b0, pos_y} - STEP_Y;
      left_x  = diff_x[8] ? 8'd0 : diff_x[7:0];
      right_x = (sum_x > MAX_X) ? MAX_X[7:0] : sum_x[7:0];
      up_y    = diff_y[7] ? 7'd0 : diff_y[6:0];
      down_y  = (sum_y > MAX_Y) ? MAX_Y[6:0] : sum_y[6:0];
   end

   // Select the new position; only a movement-state entry cycle moves.
   always_comb begin
      next_pos_x = pos_x;
      next_pos_y = pos_y;
      if (entry) begin
         case (STATE)
            ST_LEFT:  next_pos_x = left_x;
            ST_RIGHT: next_pos_x = right_x;
            ST_UP:    next_pos_y = up_y;
            ST_DOWN:  next_pos_y = down_y;
            default:  ;
         endcase
      end
   end

   // Register the state code copy and the sprite position.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_state <= ST_HOLD;
         pos_x      <= START_X_L;
         pos_y      <= START_Y_L;
      end else begin
         last_state <= STATE;
         pos_x      <= next_pos_x;
         pos_y      <= next_pos_y;
      end
   end

   // Pass control and pixel scan. Any entry cycle ends whatever pass was
   // running (and drops a stale done); entering CLEAR/DRAW starts a new one.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cx     <= '0;
         cy     <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         plot   <= 1'b0;
         x      <= '0;
         y      <= '0;
         colour <= '0;
      end else if (entry) begin
         cx   <= '0;
         cy   <= '0;
         busy <= pass_state;
         done <= 1'b0;
         plot <= 1'b0;
      end else if (busy) begin
         x      <= pos_x + {3'b000, cx};
         y      <= pos_y + {2'b00, cy};
         colour <= pix_colour;
         plot   <= 1'b1;
         if (last_px) begin
            cx   <= '0;
            cy   <= '0;
            busy <= 1'b0;
            done <= 1'b1;
         end else if (cx == CX_LAST) begin
            cx <= '0;
            cy <= cy + 5'd1;
         end else begin
            cx <= cx + 5'd1;
         end
      end else begin
         plot <= 1'b0;
      end
   end

   // Done is masked on entry cycles so it never leaks into the next pass.
   assign doneDrawing = done && !entry;

endmodule

// File: tb/tb_sprite_draw_datapath.sv
// Testbench for sprite_draw_datapath: drives state-code sequences and checks
// the pixel stream against a position/rectangle model kept in the bench.
module tb_sprite_draw_datapath;

   localparam int SPW = 8;
   localparam int SPH = 8;
   localparam int SW  = 160;
   localparam int SH  = 120;
   localparam int STP = 4;
   localparam int N   = SPW * SPH;

   localparam logic [3:0] C_HOLD  = 4'b0000;
   localparam logic [3:0] C_CLEAR = 4'b0001;
   localparam logic [3:0] C_RIGHT = 4'b0010;
   localparam logic [3:0] C_LEFT  = 4'b0011;
   localparam logic [3:0] C_DRAW  = 4'b0101;
   localparam logic [3:0] C_DOWN  = 4'b0110;
   localparam logic [3:0] C_UP    = 4'b0111;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [3:0] STATE;
   logic       doneDrawing;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       plot;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: sprite top-left in plain integers.
   int mx;
   int my;

   logic       r_plot [0:199];
   logic [7:0] r_x    [0:199];
   logic [6:0] r_y    [0:199];
   logic [2:0] r_col  [0:199];
   logic       r_done [0:199];

   sprite_draw_datapath dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .STATE       (STATE),
      .doneDrawing (doneDrawing),
      .x           (x),
      .y           (y),
      .colour      (colour),
      .plot        (plot)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   function automatic void model_move(input logic [3:0] code);
      case (code)
         C_LEFT:  mx = (mx < STP) ? 0 : mx - STP;
         C_RIGHT: mx = (mx + STP > SW - SPW) ? SW - SPW : mx + STP;
         C_UP:    my = (my < STP) ? 0 : my - STP;
         C_DOWN:  my = (my + STP > SH - SPH) ? SH - SPH : my + STP;
         default: ;
      endcase
   endfunction

   // Caller is always 1 time unit after a rising edge.
   task automatic hold_state(input logic [3:0] code, input int n);
      STATE = code;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic capture(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         r_plot[i] = plot;
         r_x[i]    = x;
         r_y[i]    = y;
         r_col[i]  = colour;
         r_done[i] = doneDrawing;
      end
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      STATE   = C_HOLD;
      mx = 76;
      my = 56;
      repeat (3) @(posedge clk);
      #1;
      vectors++; if (plot !== 1'b0) begin miscompares++; $display("FAIL reset_plot got %b want 0", plot); end
      vectors++; if (x !== 8'd0) begin miscompares++; $display("FAIL reset_x got %0d want 0", x); end
      vectors++; if (y !== 7'd0) begin miscompares++; $display("FAIL reset_y got %0d want 0", y); end
      vectors++; if (colour !== 3'd0) begin miscompares++; $display("FAIL reset_colour got %0d want 0", colour); end
      vectors++; if (doneDrawing !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", doneDrawing); end
   endtask

   task automatic test_clear_pass;
      STATE = C_CLEAR;
      reset_n = 1'b1;
      #1;
      vectors++; if (doneDrawing !== 1'b0) begin miscompares++; $display("FAIL clear_entry_done got %b want 0", doneDrawing); end
      capture(N + 1);
      for (int i = 0; i < N + 1; i++) begin
         logic ep, ed;
         int ex, ey;
         ep = (i >= 1);
         ed = (i == N);
         ex = mx + (i - 1) % SPW;
         ey = my + (i - 1) / SPW;
         vectors++; if (r_plot[i] !== ep) begin miscompares++; $display("FAIL clear_plot[%0d] got %b want %b", i, r_plot[i], ep); end
         vectors++; if (r_done[i] !== ed) begin miscompares++; $display("FAIL clear_done[%0d] got %b want %b", i, r_done[i], ed); end
         if (ep) begin
            vectors++; if (r_x[i] !== ex[7:0]) begin miscompares++; $display("FAIL clear_x[%0d] got %0d want %0d", i, r_x[i], ex); end
            vectors++; if (r_y[i] !== ey[6:0]) begin miscompares++; $display("FAIL clear_y[%0d] got %0d want %0d", i, r_y[i], ey); end
            vectors++; if (r_col[i] !== 3'b000) begin miscompares++; $display("FAIL clear_colour[%0d] got %0d want 0", i, r_col[i]); end
         end
      end
   endtask

   task automatic test_clear_to_draw;
      STATE = C_DRAW;
      #1;
      vectors++; if (doneDrawing !== 1'b0) begin miscompares++; $display("FAIL c2d_entry_done got %b want 0", doneDrawing); end
      capture(N + 2);
      for (int i = 0; i < N + 2; i++) begin
         logic ep, ed;
         int ex, ey;
         ep = (i >= 1) && (i <= N);
         ed = (i >= N);
         ex = mx + (i - 1) % SPW;
         ey = my + (i - 1) / SPW;
         vectors++; if (r_plot[i] !== ep) begin miscompares++; $display("FAIL c2d_plot[%0d] got %b want %b", i, r_plot[i], ep); end
         vectors++; if (r_done[i] !== ed) begin miscompares++; $display("FAIL c2d_done[%0d] got %b want %b", i, r_done[i], ed); end
         if (ep) begin
            vectors++; if (r_x[i] !== ex[7:0]) begin miscompares++; $display("FAIL c2d_x[%0d] got %0d want %0d", i, r_x[i], ex); end
            vectors++; if (r_y[i] !== ey[6:0]) begin miscompares++; $display("FAIL c2d_y[%0d] got %0d want %0d", i, r_y[i], ey); end
            vectors++; if (r_col[i] !== 3'b110) begin miscompares++; $display("FAIL c2d_colour[%0d] got %0d want 6", i, r_col[i]); end
         end
      end
      hold_state(C_HOLD, 2);
      vectors++; if (doneDrawing !== 1'b0) begin miscompares++; $display("FAIL c2d_hold_done got %b want 0", doneDrawing); end
   endtask

   task automatic test_multi_hold;
      hold_state(C_UP, 3);
      model_move(C_UP);
      hold_state(C_HOLD, 1);
      STATE = C_DRAW;
      capture(2);
      vectors++; if (r_y[1] !== 7'(my)) begin miscompares++; $display("FAIL multi_hold_y got %0d want %0d", r_y[1], my); end
      vectors++; if (r_x[1] !== 8'(mx)) begin miscompares++; $display("FAIL multi_hold_x got %0d want %0d", r_x[1], mx); end
      hold_state(C_HOLD, 1);
   endtask

   task automatic test_abandon;
      STATE = C_DRAW;
      capture(11);
      for (int i = 1; i < 11; i++) begin
         vectors++; if (r_plot[i] !== 1'b1) begin miscompares++; $display("FAIL abandon_pre_plot[%0d] got %b want 1", i, r_plot[i]); end
      end
      STATE = C_HOLD;
      capture(5);
      for (int i = 0; i < 5; i++) begin
         vectors++; if (r_plot[i] !== 1'b0) begin miscompares++; $display("FAIL abandon_plot[%0d] got %b want 0", i, r_plot[i]); end
         vectors++; if (r_done[i] !== 1'b0) begin miscompares++; $display("FAIL abandon_done[%0d] got %b want 0", i, r_done[i]); end
      end
   endtask

   task automatic test_random_walk;
      logic [3:0] codes [0:11];
      codes = '{C_LEFT, C_RIGHT, C_UP, C_DOWN, C_LEFT, C_RIGHT, C_UP, C_DOWN,
                4'b0100, 4'b1000, 4'b1011, 4'b1111};
      for (int it = 0; it < 6; it++) begin
         int nmoves;
         nmoves = int'($urandom_range(4, 12));
         for (int m = 0; m < nmoves; m++) begin
            logic [3:0] c;
            c = codes[$urandom_range(0, 11)];
            hold_state(c, int'($urandom_range(1, 3)));
            model_move(c);
            hold_state(C_HOLD, 1);
         end
         STATE = C_DRAW;
         capture(N + 2);
         for (int i = 0; i < N + 2; i++) begin
            logic ep, ed;
            int ex, ey;
            ep = (i >= 1) && (i <= N);
            ed = (i >= N);
            ex = mx + (i - 1) % SPW;
            ey = my + (i - 1) / SPW;
            vectors++; if (r_plot[i] !== ep) begin miscompares++; $display("FAIL walk_plot[%0d] got %b want %b", i, r_plot[i], ep); end
            vectors++; if (r_done[i] !== ed) begin miscompares++; $display("FAIL walk_done[%0d] got %b want %b", i, r_done[i], ed); end
            if (ep) begin
               vectors++; if (r_x[i] !== ex[7:0]) begin miscompares++; $display("FAIL walk_x[%0d] got %0d want %0d", i, r_x[i], ex); end
               vectors++; if (r_y[i] !== ey[6:0]) begin miscompares++; $display("FAIL walk_y[%0d] got %0d want %0d", i, r_y[i], ey); end
               vectors++; if (r_col[i] !== 3'b110) begin miscompares++; $display("FAIL walk_colour[%0d] got %0d want 6", i, r_col[i]); end
            end
         end
         hold_state(C_HOLD, 1);
      end
   endtask

   task automatic test_saturation;
      logic [3:0] dirs [0:3];
      dirs = '{C_RIGHT, C_DOWN, C_LEFT, C_UP};
      for (int d = 0; d < 4; d++) begin
         for (int k = 0; k < 40; k++) begin
            hold_state(dirs[d], 1);
            model_move(dirs[d]);
            hold_state(C_HOLD, 1);
         end
         STATE = C_DRAW;
         capture(2);
         vectors++; if (r_x[1] !== 8'(mx)) begin miscompares++; $display("FAIL sat_x[%0d] got %0d want %0d", d, r_x[1], mx); end
         vectors++; if (r_y[1] !== 7'(my)) begin miscompares++; $display("FAIL sat_y[%0d] got %0d want %0d", d, r_y[1], my); end
         hold_state(C_HOLD, 1);
      end
   endtask

   task automatic test_reset_mid;
      int cnt;
      STATE = C_DRAW;
      capture(6);
      reset_n = 1'b0;
      #1;
      vectors++; if (plot !== 1'b0) begin miscompares++; $display("FAIL rmid_plot got %b want 0", plot); end
      vectors++; if (x !== 8'd0) begin miscompares++; $display("FAIL rmid_x got %0d want 0", x); end
      vectors++; if (y !== 7'd0) begin miscompares++; $display("FAIL rmid_y got %0d want 0", y); end
      vectors++; if (colour !== 3'd0) begin miscompares++; $display("FAIL rmid_colour got %0d want 0", colour); end
      vectors++; if (doneDrawing !== 1'b0) begin miscompares++; $display("FAIL rmid_done got %b want 0", doneDrawing); end
      mx = 76;
      my = 56;
      STATE = C_CLEAR;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      capture(N + 2);
      cnt = 0;
      for (int i = 0; i < N + 2; i++) cnt += int'(r_plot[i]);
      vectors++; if (cnt != N) begin miscompares++; $display("FAIL rmid_count got %0d want %0d", cnt, N); end
      vectors++; if (r_plot[0] !== 1'b0) begin miscompares++; $display("FAIL rmid_entry_plot got %b want 0", r_plot[0]); end
      vectors++; if (r_x[1] !== 8'(mx)) begin miscompares++; $display("FAIL rmid_first_x got %0d want %0d", r_x[1], mx); end
      vectors++; if (r_y[1] !== 7'(my)) begin miscompares++; $display("FAIL rmid_first_y got %0d want %0d", r_y[1], my); end
      vectors++; if (r_col[1] !== 3'b000) begin miscompares++; $display("FAIL rmid_colour got %0d want 0", r_col[1]); end
      vectors++; if (r_done[N + 1] !== 1'b1) begin miscompares++; $display("FAIL rmid_final_done got %b want 1", r_done[N + 1]); end
   endtask

   initial begin
      test_reset;
      test_clear_pass;
      test_clear_to_draw;
      test_multi_hold;
      test_abandon;
      test_random_walk;
      test_saturation;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
